// File: rtl/immediate_decode_stage_pkg.sv
// Shared opcode constants, format codes and skid-buffer states for the
// immediate decode stage.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_R    = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/immediate_decode_stage_imm_extract.sv
// Combinational RV32/RV64 immediate extractor: opcode -> format, illegal flag
// and the sign-extended immediate in the exact ISA bit layout.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    fmt_e                fmt_sel;
    logic signed [31:0]  imm32;
    logic                s;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    assign s = instr[31];

    always_comb begin
        fmt_sel = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_sel = FMT_I;
            OPC_STORE:                                  fmt_sel = FMT_S;
            OPC_BRANCH:                                 fmt_sel = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt_sel = FMT_U;
            OPC_JAL:                                    fmt_sel = FMT_J;
            OPC_OP:                                     fmt_sel = FMT_R;
            OPC_OP_IMM_32: begin
                if (XLEN == 64) fmt_sel = FMT_I;
                else            illegal = 1'b1;
            end
            default:                                    illegal = 1'b1;
        endcase
    end

    // Everything is built at 32 bits first; RV64 only needs the sign widened.
    always_comb begin
        imm32 = '0;
        case (fmt_sel)
            FMT_I:   imm32 = {{20{s}}, instr[31:20]};
            FMT_S:   imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = sext32(imm32);
    assign fmt = fmt_sel;

endmodule

// File: rtl/immediate_decode_stage.sv
// Immediate decode pipeline stage: valid/ready in, decoded entry out, with a
// 2-entry skid buffer so the upstream ready comes straight from a flop.
module immediate_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int EN_SKID = 1
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             Flush_i,
    input  logic             InValid_i,
    output logic             InReady_o,
    input  logic [31:0]      Instruction_i,
    input  logic [XLEN-1:0]  Pc_i,
    input  logic [TAG_W-1:0] Tag_i,
    output logic             OutValid_o,
    input  logic             OutReady_i,
    output logic [XLEN-1:0]  ExtImmediate_o,
    output logic [2:0]       Format_o,
    output logic             Illegal_o,
    output logic [XLEN-1:0]  Pc_o,
    output logic [TAG_W-1:0] Tag_o
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("immediate_decode_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          in_p0;
    entry_t          out_p1;
    entry_t          skid_p1;
    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_fmt;
    logic            ext_illegal;
    skid_state_e     state_q;
    skid_state_e     state_d;
    logic            rdy_q;
    logic            in_ready;
    logic            vld_p1;
    logic            accept;
    logic            load_out;
    logic            load_skid;
    logic            skid_to_out;

    // Stage p0: decode the incoming word
    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (Instruction_i),
        .imm     (ext_imm),
        .fmt     (ext_fmt),
        .illegal (ext_illegal)
    );

    always_comb begin
        in_p0         = '0;
        in_p0.imm     = ext_imm;
        in_p0.fmt     = ext_fmt;
        in_p0.illegal = ext_illegal;
        in_p0.pc      = Pc_i;
        in_p0.tag     = Tag_i;
    end

    assign vld_p1 = (state_q != SKID_EMPTY);
    assign accept = InValid_i & in_ready;

    if (EN_SKID != 0) begin : g_skid
        assign in_ready = rdy_q;
    end else begin : g_no_skid
        // Without a skid slot the stage can only take a word if the output drains.
        assign in_ready = OutReady_i | ~vld_p1;
    end

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d  = SKID_ONE;
                    load_out = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && OutReady_i) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (OutReady_i) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (OutReady_i) begin
                    state_d     = SKID_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (Flush_i) begin
            state_d     = SKID_EMPTY;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    // Stage p1: output register and skid slot
    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= SKID_EMPTY;
            rdy_q   <= 1'b1;
            out_p1  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != SKID_FULL);
            if (load_out)         out_p1 <= in_p0;
            else if (skid_to_out) out_p1 <= skid_p1;
        end
    end

    // The skid payload is only ever read while the FSM marks it valid.
    always_ff @(posedge Clock_i) begin
        if (load_skid) skid_p1 <= in_p0;
    end

    assign InReady_o      = in_ready;
    assign OutValid_o     = vld_p1;
    assign ExtImmediate_o = out_p1.imm;
    assign Format_o       = out_p1.fmt;
    assign Illegal_o      = out_p1.illegal;
    assign Pc_o           = out_p1.pc;
    assign Tag_o          = out_p1.tag;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Scoreboard bench for immediate_decode_stage: directed vectors push expected
// entries; a monitor pops and compares on every output transfer.
module tb_immediate_decode_stage;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] imm;
        fmt_e        fmt;
        logic        ill;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc_in = '0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_ill;
    logic [31:0] out_pc;
    logic [3:0]  out_tag;

    logic        v64 = 1'b0;
    logic        rdy64;
    logic [31:0] instr64 = '0;
    logic [63:0] pc64 = '0;
    logic [3:0]  tag64 = '0;
    logic        ov64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [63:0] pco64;
    logic [3:0]  tago64;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    immediate_decode_stage #(.XLEN(32), .TAG_W(4), .EN_SKID(1)) u_dut (
        .Clock_i(clk), .Reset_i(rst), .Flush_i(flush),
        .InValid_i(in_valid), .InReady_o(in_ready),
        .Instruction_i(instr), .Pc_i(pc_in), .Tag_i(tag_in),
        .OutValid_o(out_valid), .OutReady_i(out_ready),
        .ExtImmediate_o(out_imm), .Format_o(out_fmt), .Illegal_o(out_ill),
        .Pc_o(out_pc), .Tag_o(out_tag)
    );

    immediate_decode_stage #(.XLEN(64), .TAG_W(4), .EN_SKID(1)) u_dut64 (
        .Clock_i(clk), .Reset_i(rst), .Flush_i(1'b0),
        .InValid_i(v64), .InReady_o(rdy64),
        .Instruction_i(instr64), .Pc_i(pc64), .Tag_i(tag64),
        .OutValid_o(ov64), .OutReady_i(1'b1),
        .ExtImmediate_o(imm64), .Format_o(fmt64), .Illegal_o(ill64),
        .Pc_o(pco64), .Tag_o(tago64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] tag,
                        input logic [31:0] eimm, input fmt_e efmt, input logic eill);
        logic rdy;
        logic accepted;
        exp_t e;
        in_valid = 1'b1;
        instr    = ins;
        pc_in    = pc;
        tag_in   = tag;
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) accepted = 1'b1;
        end
        if (accepted) begin
            e.imm = eimm; e.fmt = efmt; e.ill = eill; e.pc = pc; e.tag = tag;
            q.push_back(e);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout instr=%h got=not_accepted required=accepted", ins);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_imm"},       64'(out_imm),   64'd0);
        check({tag, "_fmt"},       64'(out_fmt),   64'(FMT_NONE));
        check({tag, "_illegal"},   64'(out_ill),   64'd0);
        check({tag, "_pc"},        64'(out_pc),    64'd0);
        check({tag, "_tag"},       64'(out_tag),   64'd0);
    endtask

    // Monitor: scoreboard pop on each transfer, plus payload stability while stalled.
    initial begin
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [71:0] prev_payload = '0;
        logic [71:0] cur_payload;
        forever begin
            @(negedge clk);
            cur_payload = {out_imm, out_pc, out_fmt, out_ill, out_tag};
            if (prev_stall && out_valid) begin
                n_tests++;
                if (cur_payload !== prev_payload) begin
                    n_fail++;
                    $display("FAIL stall_stable got=%h required=%h", cur_payload, prev_payload);
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_payload = cur_payload;
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got imm=%h pc=%h tag=%h required=no_output",
                             out_imm, out_pc, out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_imm !== e.imm || out_fmt !== e.fmt || out_ill !== e.ill ||
                        out_pc !== e.pc || out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL out_pc_%h got imm=%h fmt=%0d ill=%b pc=%h tag=%h required imm=%h fmt=%0d ill=%b pc=%h tag=%h",
                                 e.pc, out_imm, out_fmt, out_ill, out_pc, out_tag,
                                 e.imm, e.fmt, e.ill, e.pc, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        check("reset_ready64", 64'(rdy64), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RV64 OP-IMM-32 decodes as I with full 64-bit sign extension
        v64     = 1'b1;
        instr64 = 32'hFFF0009B;
        pc64    = 64'h8000_0000_0000_0010;
        tag64   = 4'h3;
        @(posedge clk);
        #1;
        v64 = 1'b0;
        @(negedge clk);
        check("x64_valid", 64'(ov64), 64'd1);
        check("x64_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("x64_fmt", 64'(fmt64), 64'(FMT_I));
        check("x64_illegal", 64'(ill64), 64'd0);
        check("x64_pc", pco64, 64'h8000_0000_0000_0010);
        check("x64_tag", 64'(tago64), 64'h3);
        @(posedge clk);
        #1;

        // Directed decode vectors, back to back with OutReady_i=1
        send(32'hFFF00093, 32'h1000, 4'h1, 32'hFFFFFFFF, FMT_I,    1'b0);
        send(32'hFE000EE3, 32'h1004, 4'h2, 32'hFFFFFFFC, FMT_B,    1'b0);
        send(32'h123452B7, 32'h1008, 4'h3, 32'h12345000, FMT_U,    1'b0);
        send(32'h0010006F, 32'h100C, 4'h4, 32'h00000800, FMT_J,    1'b0);
        send(32'hFE20AC23, 32'h1010, 4'h5, 32'hFFFFFFF8, FMT_S,    1'b0);
        send(32'h00001017, 32'h1014, 4'h6, 32'h00001000, FMT_U,    1'b0);
        send(32'h00000033, 32'h1018, 4'h7, 32'h00000000, FMT_R,    1'b0);
        send(32'hFFFFFFFF, 32'h101C, 4'h8, 32'h00000000, FMT_NONE, 1'b1);
        send(32'hFFF0009B, 32'h1020, 4'h9, 32'h00000000, FMT_NONE, 1'b1);
        wait_drain("drain_vectors");

        // Backpressure: two accepted, third sees InReady_o=0
        out_ready = 1'b0;
        send(32'h00500113, 32'h2000, 4'hA, 32'h00000005, FMT_I, 1'b0);
        send(32'h80000537, 32'h2004, 4'hB, 32'h80000000, FMT_U, 1'b0);
        in_valid = 1'b1;
        instr    = 32'h00100093;
        pc_in    = 32'h2008;
        tag_in   = 4'hC;
        @(negedge clk);
        check("bp_ready_cycle3", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_pc", 64'(out_pc), 64'h2000);
        repeat (3) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("drain_backpressure");

        // Flush while FULL with a pending offer
        out_ready = 1'b0;
        send(32'h00A00093, 32'h3000, 4'h1, 32'h0000000A, FMT_I, 1'b0);
        send(32'h00B00093, 32'h3004, 4'h2, 32'h0000000B, FMT_I, 1'b0);
        in_valid = 1'b1;
        instr    = 32'h00C00093;
        pc_in    = 32'h3008;
        tag_in   = 4'h3;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_full_out_valid", 64'(out_valid), 64'd0);
        check("flush_full_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Flush in ONE drops a same-cycle accept
        out_ready = 1'b0;
        send(32'h00D00093, 32'h4000, 4'h4, 32'h0000000D, FMT_I, 1'b0);
        in_valid = 1'b1;
        instr    = 32'h00E00093;
        pc_in    = 32'h4004;
        tag_in   = 4'h5;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_one_in_ready_before", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_one_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-stall discards both entries and restores reset values
        out_ready = 1'b0;
        send(32'h7FF00093, 32'h5000, 4'h6, 32'h000007FF, FMT_I, 1'b0);
        send(32'h80000093, 32'h5004, 4'h7, 32'hFFFFF800, FMT_I, 1'b0);
        in_valid = 1'b1;
        instr    = 32'h00100093;
        pc_in    = 32'h5008;
        tag_in   = 4'h8;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset_values("midstall_reset");
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send(32'hFFF00093, 32'h6000, 4'hF, 32'hFFFFFFFF, FMT_I, 1'b0);
        wait_drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
